// File: rtl/pad_btn_conditioner.sv
// Paddle push-button conditioner: sync, debounce and auto-repeat for two
// active-low buttons, producing one-clk active-low move strobes.
module pad_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic playing,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic btnLeft,
    output logic btnRight
);

    localparam int NUM_LANES = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    // Lane 0 = left, lane 1 = right. All levels are active-low (1 = released).
    logic [NUM_LANES-1:0]            raw, s1, s2, acc, acc_q, fire;
    logic [NUM_LANES-1:0][CNT_W-1:0] dcnt, rcnt, rcnt_nx;
    logic [NUM_LANES-1:0][1:0]       state, state_nx;
    logic                            keep;

    assign raw = {btn_right_raw, btn_left_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '1;
            s2    <= '1;
            acc   <= '1;
            acc_q <= '1;
            dcnt  <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            acc_q <= acc;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (s2[i] == acc[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    acc[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press is taken on the accepted-level falling edge so a button already
    // held when play starts needs a release/press before it moves the paddle.
    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        fire     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!playing) begin
                state_nx[i] = IDLE;
                rcnt_nx[i]  = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (!acc[i] && acc_q[i]) begin
                            fire[i]     = 1'b1;
                            state_nx[i] = DELAY;
                            rcnt_nx[i]  = '0;
                        end
                    end
                    DELAY: begin
                        if (acc[i]) begin
                            state_nx[i] = IDLE;
                            rcnt_nx[i]  = '0;
                        end else if (rcnt[i] == RD_LAST) begin
                            fire[i]     = 1'b1;
                            state_nx[i] = REPEAT;
                            rcnt_nx[i]  = '0;
                        end else begin
                            rcnt_nx[i]  = rcnt[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (acc[i]) begin
                            state_nx[i] = IDLE;
                            rcnt_nx[i]  = '0;
                        end else if (rcnt[i] == RP_LAST) begin
                            fire[i]     = 1'b1;
                            rcnt_nx[i]  = '0;
                        end else begin
                            rcnt_nx[i]  = rcnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nx[i] = IDLE;
                        rcnt_nx[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Both held, or both firing together, means "no move": suppress both.
    assign keep = playing & (acc[0] | acc[1]) & ~(fire[0] & fire[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= {NUM_LANES{IDLE}};
            rcnt     <= '0;
            btnLeft  <= 1'b1;
            btnRight <= 1'b1;
        end else begin
            state    <= state_nx;
            rcnt     <= rcnt_nx;
            btnLeft  <= ~(fire[0] & keep);
            btnRight <= ~(fire[1] & keep);
        end
    end

endmodule

// File: tb/tb_pad_btn_conditioner.sv
// Bench for pad_btn_conditioner: directed scenarios plus random button
// activity, every cycle compared against a schedule-based reference model.
module tb_pad_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic playing = 1'b0;
    logic btn_left_raw = 1'b1;
    logic btn_right_raw = 1'b1;
    logic btnLeft, btnRight;

    int n_total = 0;
    int n_pass = 0;

    pad_btn_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .playing(playing),
        .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
        .btnLeft(btnLeft), .btnRight(btnRight)
    );

    always #5 clk = ~clk;

    // Reference model: raw history for the 2-clk sync lag, a run-length
    // debouncer, and a press age whose strobe schedule is 0, RD, RD+k*RP.
    bit m_h1[2], m_h2[2], m_acc[2], m_acc_old[2], m_act[2], m_out[2];
    int m_run[2], m_age[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_h1[i] = 1; m_h2[i] = 1; m_acc[i] = 1; m_acc_old[i] = 1;
            m_act[i] = 0; m_out[i] = 1; m_run[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_step(input bit l, input bit r, input bit p);
        bit stb[2];
        bit both;
        bit rw[2];
        rw[0] = l; rw[1] = r;
        both = !m_acc[0] && !m_acc[1];
        for (int i = 0; i < 2; i++) begin
            stb[i] = 0;
            if (!p) begin
                m_act[i] = 0;
            end else if (m_act[i]) begin
                if (m_acc[i]) m_act[i] = 0;
                else begin
                    m_age[i]++;
                    stb[i] = (m_age[i] == RD) || (m_age[i] > RD && (m_age[i] - RD) % RP == 0);
                end
            end else if (!m_acc[i] && m_acc_old[i]) begin
                m_act[i] = 1; m_age[i] = 0; stb[i] = 1;
            end
        end
        for (int i = 0; i < 2; i++) m_out[i] = !(stb[i] && !stb[1-i] && !both);
        for (int i = 0; i < 2; i++) begin
            m_acc_old[i] = m_acc[i];
            if (m_h2[i] != m_acc[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin m_acc[i] = m_h2[i]; m_run[i] = 0; end
            end else m_run[i] = 0;
            m_h2[i] = m_h1[i];
            m_h1[i] = rw[i];
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic edge_check(input bit l, input bit r, input bit p, input string tag);
        @(posedge clk); #1;
        model_step(l, r, p);
        chk({tag, "_L"}, btnLeft, m_out[0]);
        chk({tag, "_R"}, btnRight, m_out[1]);
    endtask

    task automatic cyc(input bit l, input bit r, input bit p, input string tag);
        @(negedge clk);
        btn_left_raw = l; btn_right_raw = r; playing = p;
        edge_check(l, r, p, tag);
    endtask

    initial begin
        int lpos[$];
        int rlow, llow, r0, found, cnt;

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_L", btnLeft, 1'b1);
        chk("rst_R", btnRight, 1'b1);
        @(negedge clk); rst_n = 1'b1; playing = 1'b1;
        edge_check(1, 1, 1, "rel");

        // 1: idle
        rlow = 0; llow = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1, 1, 1, "idle");
            if (btnLeft === 1'b0) llow++;
            if (btnRight === 1'b0) rlow++;
        end
        chk_int("idle_lows", llow + rlow, 0);

        // 2: bounce then hold; stable low starts at call 6 (sampled at that edge)
        rlow = 0;
        for (int k = 0; k < 36; k++) begin
            cyc((k < 6) ? ((k % 2) == 1) : 1'b0, 1, 1, "press");
            if (btnLeft === 1'b0) lpos.push_back(k - 6);
            if (btnRight === 1'b0) rlow++;
        end
        chk_int("press_npulse", lpos.size(), 4);
        if (lpos.size() == 4) begin
            chk_int("press_first", lpos[0], 6);
            chk_int("press_rep1", lpos[1] - lpos[0], 10);
            chk_int("press_rep2", lpos[2] - lpos[0], 15);
            chk_int("press_rep3", lpos[3] - lpos[0], 20);
        end
        chk_int("press_right_quiet", rlow, 0);
        for (int k = 0; k < 20; k++) cyc(1, 1, 1, "release");

        // 3: short right glitch, then a clean press to verify counter cleared
        rlow = 0;
        for (int k = 0; k < 23; k++) begin
            cyc(1, (k < 3) ? 1'b0 : 1'b1, 1, "glitch");
            if (btnRight === 1'b0) rlow++;
        end
        chk_int("glitch_quiet", rlow, 0);
        lpos.delete();
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, 1, "rpress");
            if (btnRight === 1'b0) lpos.push_back(k);
        end
        chk_int("rpress_n", lpos.size(), 1);
        if (lpos.size() == 1) chk_int("rpress_first", lpos[0], 6);
        for (int k = 0; k < 20; k++) cyc(1, 1, 1, "rrel");

        // 4: left held, right pressed during left's DELAY
        llow = 0;
        for (int k = 0; k < 9; k++) cyc(0, 1, 1, "both_pre");
        r0 = 0;
        for (int k = 0; k < 60; k++) begin
            cyc(0, (k < 20) ? 1'b0 : 1'b1, 1, "both");
            if (k >= 6 && k <= 25 && (btnLeft === 1'b0 || btnRight === 1'b0)) llow++;
        end
        chk_int("both_quiet", llow, 0);
        for (int k = 0; k < 20; k++) cyc(1, 1, 1, "both_rel");

        // 5: playing gating
        llow = 0;
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, "gate_off");
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 1, "gate_on");
            if (btnLeft === 1'b0) llow++;
        end
        chk_int("gate_no_strobe", llow, 0);
        for (int k = 0; k < 15; k++) cyc(1, 1, 1, "gate_rel");
        lpos.delete();
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 1, "gate_press");
            if (btnLeft === 1'b0) lpos.push_back(k);
        end
        chk_int("gate_press_n", lpos.size(), 1);
        if (lpos.size() == 1) chk_int("gate_press_first", lpos[0], 6);

        // 6: async reset while btnLeft is low (left still held, in REPEAT)
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            cyc(0, 1, 1, "arst_wait");
            if (btnLeft === 1'b0) found = 1;
        end
        chk_int("arst_found_low", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_L_now", btnLeft, 1'b1);
        chk("arst_R_now", btnRight, 1'b1);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        lpos.delete();
        edge_check(0, 1, 1, "arst_rel");
        if (btnLeft === 1'b0) lpos.push_back(0);
        for (int k = 1; k < 15; k++) begin
            cyc(0, 1, 1, "arst_hold");
            if (btnLeft === 1'b0) lpos.push_back(k);
        end
        chk_int("arst_n", lpos.size(), 1);
        if (lpos.size() == 1) chk_int("arst_first", lpos[0], 6);
        for (int k = 0; k < 15; k++) cyc(1, 1, 1, "arst_done");

        // Random segments of held/released/bouncing buttons and play gating
        for (int s = 0; s < 250; s++) begin
            bit l, r, p;
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 7) != 0);
            cnt = $urandom_range(1, 25);
            for (int k = 0; k < cnt; k++) begin
                if ($urandom_range(0, 15) == 0) cyc(~l, r, p, "rand");
                else cyc(l, r, p, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
